// File: rtl/mac_arbiter_pkg.sv
// Shared operand width and operand/result types for the MAC arbiter slice.
package param_P;
    localparam int P = 8;

    typedef struct packed {
        logic [P-1:0] a;
        logic [P-1:0] b;
        logic [P-1:0] c;
    } mac_op_t;

    typedef logic [2*P-1:0] mac_res_t;
endpackage

// File: rtl/mac_pipe.sv
// Two-stage stallable multiply-accumulate pipeline: stage 1 holds AA*BB and CC,
// the output register holds AA*BB + CC; both stages move only when adv is high.
module mac_pipe
    import param_P::*;
#(
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             adv,
    input  logic [P-1:0]     a,
    input  logic [P-1:0]     b,
    input  logic [P-1:0]     c,
    input  logic [IDW-1:0]   id,
    output logic             out_valid,
    output logic [IDW-1:0]   out_id,
    output logic [2*P-1:0]   out_data
);

    logic           s1_valid;
    mac_res_t       s1_prod;
    mac_res_t       s1_addend;
    logic [IDW-1:0] s1_id;

    // The sum cannot overflow 2P bits, so no saturation is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_addend <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_prod   <= mac_res_t'(a) * mac_res_t'(b);
            s1_addend <= mac_res_t'(c);
            s1_id     <= id;
            out_valid <= s1_valid;
            out_id    <= s1_id;
            out_data  <= s1_prod + s1_addend;
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined MAC between NREQ requesters.
// Define MAC_ARB_PRIO_EN to give requester 0 fixed highest priority.
module mac_arbiter
    import param_P::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              busy,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*P-1:0] req_a,
    input  logic [NREQ*P-1:0] req_b,
    input  logic [NREQ*P-1:0] req_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [2*P-1:0]    res_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic           found;
    logic           adv;
    logic           can_grant;
    logic           transfer;
    logic           s1_busy;
    mac_op_t        op;

    assign adv       = !(res_valid && !res_ready);
    assign can_grant = (state == RUN) && en && adv;
    assign busy      = (state != IDLE);
    assign transfer  = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // s1_busy shadows the pipe's stage-1 valid so DRAIN can see when it is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= IDW'(NREQ - 1);
            s1_busy <= 1'b0;
        end else begin
            if (adv) begin
                s1_busy <= transfer;
            end
`ifdef MAC_ARB_PRIO_EN
            if (transfer && (sel != '0)) begin
                rr_ptr <= sel;
            end
`else
            if (transfer) begin
                rr_ptr <= sel;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if (!s1_busy && !res_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
`ifdef MAC_ARB_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k < NREQ; k++) begin
            idx = 1 + ((int'(rr_ptr) - 1 + k) % (NREQ - 1));
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (can_grant && found) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        op.a = req_a[int'(sel)*P +: P];
        op.b = req_b[int'(sel)*P +: P];
        op.c = req_c[int'(sel)*P +: P];
    end

    mac_pipe #(
        .IDW(IDW)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (transfer),
        .adv      (adv),
        .a        (op.a),
        .b        (op.b),
        .c        (op.c),
        .id       (sel),
        .out_valid(res_valid),
        .out_id   (res_id),
        .out_data (res_data)
    );

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the arbiter and MAC.
module tb_mac_arbiter;
    import param_P::*;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              busy;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*P-1:0] req_a;
    logic [NREQ*P-1:0] req_b;
    logic [NREQ*P-1:0] req_c;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [2*P-1:0]    res_data;

    logic [P-1:0] op_a [NREQ];
    logic [P-1:0] op_b [NREQ];
    logic [P-1:0] op_c [NREQ];

    int checks = 0;
    int errors = 0;

    // Model: FSM mode (0 idle, 1 run, 2 drain), pointer, and the two in-flight results.
    typedef struct {
        bit v;
        int id;
        int data;
    } slot_t;

    slot_t m_s1;
    slot_t m_out;
    int    m_state;
    int    m_ptr;
    int    cyc;
    int    m_grants [$];
    int    xfer_cyc [$];
    int    obs_grant[$];
    int    obs_id   [$];
    int    obs_data [$];
    int    obs_cyc  [$];

    mac_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .busy     (busy),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_data (res_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pickGrant();
`ifdef MAC_ARB_PRIO_EN
        if (req_valid[0]) return 0;
        for (int k = 1; k < NREQ; k++) begin
            int i;
            i = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
            if (req_valid[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic setOperands(input int i, input int a, input int b, input int c);
        op_a[i] = P'(a);
        op_b[i] = P'(b);
        op_c[i] = P'(c);
    endtask

    task automatic newOperands(input int i);
        op_a[i] = ($urandom_range(0, 3) == 0) ? '1 : P'($urandom);
        op_b[i] = ($urandom_range(0, 3) == 0) ? '1 : P'($urandom);
        op_c[i] = ($urandom_range(0, 3) == 0) ? '1 : P'($urandom);
    endtask

    task automatic modelReset();
        m_state = 0;
        m_ptr   = NREQ - 1;
        m_s1    = '{v: 1'b0, id: 0, data: 0};
        m_out   = '{v: 1'b0, id: 0, data: 0};
        cyc     = 0;
        m_grants.delete();
        xfer_cyc.delete();
        obs_grant.delete();
        obs_id.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_res_data", res_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Called at a falling edge with inputs set; checks this cycle and advances one clock.
    task automatic applyStimulus(input bit refill);
        int          g;
        bit          adv;
        bit          empty;
        logic [NREQ-1:0] exp_ready;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*P +: P] = op_a[i];
            req_b[i*P +: P] = op_b[i];
            req_c[i*P +: P] = op_c[i];
        end
        #1;
        checkOutput("busy", busy, (m_state != 0));
        checkOutput("res_valid", res_valid, m_out.v);
        if (m_out.v) begin
            checkOutput("res_id", res_id, m_out.id);
            checkOutput("res_data", res_data, m_out.data);
        end
        adv = !(m_out.v && !res_ready);
        g   = (m_state == 1 && en && adv) ? pickGrant() : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", req_ready, exp_ready);

        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) obs_grant.push_back(i);
        end
        if (res_valid && res_ready) begin
            obs_id.push_back(int'(res_id));
            obs_data.push_back(int'(res_data));
            obs_cyc.push_back(cyc);
        end

        empty = !m_s1.v && !m_out.v;
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 2;
            default: begin
                if (en) m_state = 1;
                else if (empty) m_state = 0;
            end
        endcase
        if (adv) begin
            m_out = m_s1;
            m_s1  = '{v: 1'b0, id: 0, data: 0};
            if (g >= 0) begin
                m_s1 = '{v: 1'b1, id: g,
                         data: int'(op_a[g]) * int'(op_b[g]) + int'(op_c[g])};
                m_grants.push_back(g);
                xfer_cyc.push_back(cyc);
`ifdef MAC_ARB_PRIO_EN
                if (g != 0) m_ptr = g;
`else
                m_ptr = g;
`endif
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (g >= 0) begin
            if (refill) newOperands(g);
            else req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        int exp_rr [5];
        for (int i = 0; i < NREQ; i++) setOperands(i, 0, 0, 0);

        // Single request with maximal operands.
        doReset();
        en = 1'b1;
        setOperands(0, 'hFF, 'hFF, 'hFF);
        req_valid[0] = 1'b1;
        repeat (6) applyStimulus(1'b0);
        checkOutput("single_count", obs_id.size(), 1);
        if (obs_id.size() > 0 && obs_grant.size() > 0) begin
            checkOutput("single_data", obs_data[0], 'hFF00);
            checkOutput("single_id", obs_id[0], 0);
            checkOutput("single_first_grant_cycle", xfer_cyc[0], 1);
            checkOutput("single_latency", obs_cyc[0] - xfer_cyc[0], 2);
        end

        // Round robin with every requester holding valid.
        doReset();
        en = 1'b1;
        for (int i = 0; i < NREQ; i++) newOperands(i);
        req_valid = '1;
        repeat (6) applyStimulus(1'b1);
        req_valid = '0;
        repeat (4) applyStimulus(1'b0);
`ifdef MAC_ARB_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        checkOutput("rr_grant_count", obs_grant.size(), 5);
        checkOutput("rr_result_count", obs_id.size(), 5);
        if (obs_grant.size() == 5 && obs_id.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("rr_grant", obs_grant[i], exp_rr[i]);
                checkOutput("rr_result_id", obs_id[i], exp_rr[i]);
                checkOutput("rr_result_spacing", obs_cyc[i] - obs_cyc[0], i);
            end
        end

        // Backpressure with two results in flight.
        doReset();
        en = 1'b1;
        setOperands(1, 3, 5, 7);
        setOperands(2, 10, 20, 1);
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        repeat (3) applyStimulus(1'b0);
        res_ready = 1'b0;
        setOperands(3, 2, 2, 2);
        req_valid[3] = 1'b1;
        repeat (3) begin
            #1;
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_res_id", res_id, 1);
            checkOutput("bp_res_data", res_data, 22);
            applyStimulus(1'b0);
        end
        res_ready = 1'b1;
        repeat (5) applyStimulus(1'b0);
        checkOutput("bp_result_count", obs_id.size(), 3);
        if (obs_id.size() == 3) begin
            checkOutput("bp_id0", obs_id[0], 1);
            checkOutput("bp_id1", obs_id[1], 2);
            checkOutput("bp_id2", obs_id[2], 3);
            checkOutput("bp_data0", obs_data[0], 22);
            checkOutput("bp_data1", obs_data[1], 201);
            checkOutput("bp_data2", obs_data[2], 6);
        end

        // Drain with two operations in flight.
        doReset();
        en = 1'b1;
        setOperands(0, 1, 2, 3);
        setOperands(1, 4, 5, 6);
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        repeat (3) applyStimulus(1'b0);
        en = 1'b0;
        setOperands(2, 9, 9, 9);
        req_valid[2] = 1'b1;
        repeat (4) applyStimulus(1'b0);
        #1;
        checkOutput("drain_busy", busy, 0);
        checkOutput("drain_grant_count", obs_grant.size(), 2);
        checkOutput("drain_result_count", obs_id.size(), 2);
        if (obs_id.size() == 2) begin
            checkOutput("drain_data0", obs_data[0], 5);
            checkOutput("drain_data1", obs_data[1], 26);
        end
        req_valid = '0;

        // Asynchronous reset while a result is presented.
        doReset();
        en = 1'b1;
        for (int i = 0; i < NREQ; i++) newOperands(i);
        req_valid = '1;
        repeat (4) applyStimulus(1'b1);
        #1;
        checkOutput("midrst_pre_valid", res_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        req_valid = 4'b1101;
        repeat (3) applyStimulus(1'b0);
        checkOutput("midrst_no_stale", obs_id.size(), 0);
        if (obs_grant.size() > 0) checkOutput("midrst_first_grant", obs_grant[0], 0);
        else checkOutput("midrst_grant_seen", obs_grant.size(), 1);
        req_valid = '0;
        repeat (4) applyStimulus(1'b0);

`ifdef MAC_ARB_PRIO_EN
        // Fixed priority for requester 0 over a waiting requester 2.
        doReset();
        en = 1'b1;
        newOperands(0);
        newOperands(2);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        repeat (4) applyStimulus(1'b1);
        req_valid[0] = 1'b0;
        repeat (4) applyStimulus(1'b0);
        checkOutput("prio_grant_count", obs_grant.size(), 4);
        if (obs_grant.size() == 4) begin
            for (int i = 0; i < 3; i++) checkOutput("prio_req0", obs_grant[i], 0);
            checkOutput("prio_req2", obs_grant[3], 2);
        end
`endif

        // Randomized traffic against the model.
        doReset();
        en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    req_valid[i] = 1'b1;
                    newOperands(i);
                end else if (req_valid[i] && $urandom_range(0, 99) < 5) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 99) < 5) en = ~en;
            res_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0);
        end
        en        = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (6) applyStimulus(1'b0);
        #1;
        checkOutput("rand_final_busy", busy, 0);
        checkOutput("rand_results_vs_grants", obs_id.size(), m_grants.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Round-robin arbiter and sequencer that shares one pipelined multiply-accumulate unit (data_out = AA*BB + CC, 2P-bit result) between NREQ requesters. It accepts at most one operand set per cycle over a valid/ready handshake, pushes it through a stallable two-stage MAC pipeline and returns the result tagged with the requester index. It also handles enable/drain sequencing. It sits between the operand producers and the single shared MAC resource.

## Interface
- P, from package param_P: operand width in bits; results are 2P bits.
- NREQ, default 4: number of requesters, 2..16.
- IDW, default $clog2(NREQ): width of the requester index.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low requests a drain to IDLE.
- busy  out  1  high in RUN or DRAIN.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  NREQ*P  packed AA operands; requester i occupies bits [i*P +: P].
- req_b  in  NREQ*P  packed BB operands, same packing.
- req_c  in  NREQ*P  packed CC addends, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept from sink.
- res_id  out  IDW  index of the requester that owns res_data.
- res_data  out  2P  AA*BB + CC.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when both pipeline stages and the output register are empty.
  - DRAIN -> RUN when en=1 returns before empty; pipeline contents are kept.
- Pipeline advance: adv = !(res_valid && !res_ready). All stages move together when adv=1.
- Grant:
  - Granting happens only in RUN with adv=1.
  - Selection is the first asserted req_valid, searching from rr_ptr+1 upward with wrap at NREQ-1 -> 0.
  - req_ready is combinational, one-hot on the selected index.
  - A transfer occurs when req_valid[i] && req_ready[i]. rr_ptr then loads i.
  - With no transfer, rr_ptr holds.
- Requester obligations: req_valid must stay high and operands stable until the transfer. A requester may drop valid before it is granted; no transfer occurs.
- Stage 1 registers: AA*BB (2P bits), CC zero-extended to 2P, id, and a valid bit.
- Stage 2 (output register): product + CC, id, valid.
- Arithmetic: the result cannot overflow, since (2^P-1)^2 + (2^P-1) < 2^(2P). No saturation logic.
- Reset values: busy=0, req_ready=0, res_valid=0, res_id=0, res_data=0, rr_ptr=NREQ-1 (so requester 0 wins first), all stage valids 0.
- Reset mid-operation: in-flight operations are discarded without any result output.

## Timing
- Latency: an operand set transferred at edge t appears with res_valid=1 after edge t+2, provided no stall occurs.
- Throughput: one operation per cycle while res_ready=1.
- When res_ready=0 and res_valid=1:
  - the whole pipeline freezes;
  - req_ready=0;
  - res_data and res_id hold stable.
- A result is consumed on a cycle with res_valid && res_ready. A new result may load on that same edge.
- en falling: no grant in the following cycle. Up to 2 in-flight results still emerge.
- busy falls on the edge that enters IDLE.

## Configuration
- MAC_ARB_PRIO_EN defined:
  - requester 0 has fixed highest priority; it is granted whenever req_valid[0]=1 and granting is allowed;
  - the round-robin search applies only among indices 1..NREQ-1;
  - rr_ptr is not updated by grants to requester 0.
- MAC_ARB_PRIO_EN undefined: pure round robin over all NREQ requesters.

## Structure
- Package param_P holds P, typedef mac_op_t (a, b, c as logic [P-1:0]) and typedef mac_res_t (logic [2*P-1:0]).
- The FSM state enum is local to mac_arbiter.
- Sub-module mac_pipe: two-stage stallable MAC with inputs in_valid, adv, a, b, c, id and outputs out_valid, out_id, out_data.
- mac_arbiter owns the FSM, grant logic and rr_ptr.

## Test plan
Defaults P=8, NREQ=4, en=1, res_ready=1 unless stated.
- Single request: req0 with a=0xFF, b=0xFF, c=0xFF -> res_data=0xFF00, res_id=0 two edges after the transfer.
- Round robin: all four requesters hold valid -> grants 0,1,2,3,0 on consecutive cycles; results come back in the same order, one per cycle.
- Backpressure: res_ready=0 for 3 cycles while 2 results are in flight -> res_data/res_id stable, req_ready=0; on release, both results come out in order with none lost or duplicated.
- Drain: en=0 with 2 operations in flight -> no further grants, 2 results emerge, then IDLE and busy=0.
- Reset mid-stream: rst_n=0 asserted asynchronously with res_valid=1 -> res_valid=0 immediately; after reset release, requester 0 is granted first.
- Priority (MAC_ARB_PRIO_EN defined): req0 and req2 both valid for 3 cycles -> req0 granted every cycle, req2 only after req0 drops valid.
